// File: rtl/mux2way5_sel.sv
// mux2way5_sel
// ----------------------------------------------------------------------------
// Two-input selector for the MIPS datapath, for example the register
// destination choice between rt and rd. It has a zero-latency combinational
// result for use in the same cycle, and a registered copy of that result and
// of the select for the next pipeline stage.
//
// Optional feature macro: MUX2WAY5_SWITCH_CNT_EN
//   When this macro is defined, the block adds the CNT_W parameter and the
//   switch_cnt output. switch_cnt is a saturating count of select transitions.
//   When the macro is not defined, the parameter, the port and all counter
//   logic are left out. Everything else behaves the same in both builds.
//
// Parameters:
//   WIDTH  data width of a, b, out and out_q (default 5)
//   CNT_W  width of switch_cnt (default 8, only with the optional feature)
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous reset, active low
//   a           in   WIDTH  data input chosen when sel = 0
//   b           in   WIDTH  data input chosen when sel = 1
//   sel         in   1      select
//   en          in   1      capture enable for out_q and sel_q
//   out         out  WIDTH  combinational mux result
//   out_q       out  WIDTH  mux result captured at the last enabled edge
//   sel_q       out  1      select captured at the last enabled edge
//   switch_cnt  out  CNT_W  saturating count of sel transitions (optional)
// ----------------------------------------------------------------------------
module mux2way5_sel #(
  parameter int WIDTH = 5
`ifdef MUX2WAY5_SWITCH_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q
`ifdef MUX2WAY5_SWITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] switch_cnt
`endif
);

  // Shared by the combinational output and the capture path, so both always
  // make the same choice.
  function automatic logic [WIDTH-1:0] mux_pick(
    input logic [WIDTH-1:0] in0,
    input logic [WIDTH-1:0] in1,
    input logic             s
  );
    logic [WIDTH-1:0] res;
    case (s)
      1'b0:    res = in0;
      1'b1:    res = in1;
      default: res = in0;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] out_d;
  logic             sel_d;

  // Same-cycle datapath result. Neither rst_n nor en affects it.
  always_comb begin
    out = mux_pick(a, b, sel);
  end

  // Capture or hold the pipeline copies, depending on en.
  always_comb begin
    out_d = out_q;
    sel_d = sel_q;
    if (en) begin
      out_d = mux_pick(a, b, sel);
      sel_d = sel;
    end else begin
      out_d = out_q;
      sel_d = sel_q;
    end
  end

  // Pipeline registers. They clear as soon as reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= {WIDTH{1'b0}};
      sel_q <= 1'b0;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end

`ifdef MUX2WAY5_SWITCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             sel_prev_d;
  logic             sel_prev_q;
  logic [CNT_W-1:0] switch_cnt_d;
  logic [CNT_W-1:0] switch_cnt_q;

  // sel_prev follows sel on every edge, whether or not en is set. The counter
  // goes up on any edge where sel differs from the value it had at the
  // previous edge. It stops at its maximum instead of wrapping.
  always_comb begin
    sel_prev_d   = sel;
    switch_cnt_d = switch_cnt_q;
    if ((sel != sel_prev_q) && (switch_cnt_q != CNT_MAX)) begin
      switch_cnt_d = switch_cnt_q + CNT_W'(1);
    end else begin
      switch_cnt_d = switch_cnt_q;
    end
  end

  // Transition-tracking registers. They clear together with the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_prev_q   <= 1'b0;
      switch_cnt_q <= {CNT_W{1'b0}};
    end else begin
      sel_prev_q   <= sel_prev_d;
      switch_cnt_q <= switch_cnt_d;
    end
  end

  assign switch_cnt = switch_cnt_q;
`endif

endmodule

// File: tb/tb_mux2way5_sel.sv
module tb_mux2way5_sel;

  localparam int WIDTH = 5;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             sel_q;
`ifdef MUX2WAY5_SWITCH_CNT_EN
  logic [CNT_W-1:0] switch_cnt;
`endif

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state
  int m_out_q;
  int m_sel_q;
  int m_cnt;
  int m_sel_prev;

  always #5 clk = ~clk;

`ifdef MUX2WAY5_SWITCH_CNT_EN
  mux2way5_sel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
`else
  mux2way5_sel #(.WIDTH(WIDTH)) dut (
`endif
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .en    (en),
    .out   (out),
    .out_q (out_q),
    .sel_q (sel_q)
`ifdef MUX2WAY5_SWITCH_CNT_EN
    ,
    .switch_cnt (switch_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected selector output: pick one entry out of the two inputs.
  function automatic int pick(input int in0, input int in1, input int s);
    int choices[2];
    choices[0] = in0;
    choices[1] = in1;
    return choices[s];
  endfunction

  function automatic int cnt_max();
    return (1 << CNT_W) - 1;
  endfunction

  task automatic model_reset();
    m_out_q    = 0;
    m_sel_q    = 0;
    m_cnt      = 0;
    m_sel_prev = 0;
  endtask

  // Advance one rising edge and update the model from the inputs seen there.
  task automatic tick();
    @(posedge clk);
    if (rst_n === 1'b1) begin
      if (en === 1'b1) begin
        m_out_q = pick(int'(a), int'(b), int'(sel));
        m_sel_q = int'(sel);
      end
      if ((int'(sel) != m_sel_prev) && (m_cnt < cnt_max())) m_cnt = m_cnt + 1;
      m_sel_prev = int'(sel);
    end
    #1;
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, " out_q"}, 32'(out_q), 32'(m_out_q));
    check_val({tag, " sel_q"}, 32'(sel_q), 32'(m_sel_q));
`ifdef MUX2WAY5_SWITCH_CNT_EN
    check_val({tag, " switch_cnt"}, 32'(switch_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic check_out(input string tag);
    check_val(tag, 32'(out), 32'(pick(int'(a), int'(b), int'(sel))));
  endtask

  initial begin
    int sat_exp[5];
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

    // Reset with no clock edge yet
    rst_n = 1'b0; en = 1'b0; a = 5'd0; b = 5'd0; sel = 1'b0;
    model_reset();
    #2;
    check_val("reset out_q", 32'(out_q), 32'd0);
    check_val("reset sel_q", 32'(sel_q), 32'd0);
    check_regs("reset");

    // Combinational sweeps (run under reset: out must not care)
    b = 5'd0;
    for (int i = 0; i < 16; i++) begin
      a = WIDTH'(i);
      sel = 1'b0; #5; check_out("sweep_a sel0");
      sel = 1'b1; #5; check_out("sweep_a sel1");
    end
    a = 5'd7; sel = 1'b0; #1; check_val("sweep_a a7", 32'(out), 32'd7);
    a = 5'd15;
    for (int i = 0; i < 16; i++) begin
      b = WIDTH'(i);
      sel = 1'b1; #5; check_out("sweep_b sel1");
      sel = 1'b0; #5; check_out("sweep_b sel0");
    end
    b = 5'd9; sel = 1'b1; #1; check_val("sweep_b b9", 32'(out), 32'd9);

    // Full width and a == b
    a = 5'b11111; b = 5'b00000;
    sel = 1'b0; #1; check_val("full sel0", 32'(out), 32'd31);
    sel = 1'b1; #1; check_val("full sel1", 32'(out), 32'd0);
    a = 5'd13; b = 5'd13;
    sel = 1'b0; #1; check_val("a_eq_b sel0", 32'(out), 32'd13);
    sel = 1'b1; #1; check_val("a_eq_b sel1", 32'(out), 32'd13);
    check_regs("still reset");

    // Release reset away from the edge, then directed capture/hold
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    a = 5'd3; b = 5'd28; sel = 1'b1; en = 1'b1;
    tick();
    check_val("capture out_q", 32'(out_q), 32'd28);
    check_val("capture sel_q", 32'(sel_q), 32'd1);
    check_regs("capture");
    en = 1'b0; sel = 1'b0;
    tick();
    check_val("hold out_q", 32'(out_q), 32'd28);
    check_regs("hold");

    // Asynchronous reset between edges
    sel = 1'b1; en = 1'b1;
    tick();
    #2; rst_n = 1'b0; #1;
    model_reset();
    check_val("async out_q", 32'(out_q), 32'd0);
    check_regs("async");
    check_out("async out");
    @(negedge clk); rst_n = 1'b1; sel = 1'b0;

    // Toggle sel on consecutive edges (counter saturation)
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sel = ~sel;
      tick();
`ifdef MUX2WAY5_SWITCH_CNT_EN
      check_val("sat switch_cnt", 32'(switch_cnt), 32'(sat_exp[k]));
`endif
      check_regs("toggle");
    end
    #2; rst_n = 1'b0; #1;
    model_reset();
    check_regs("sat reset");
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0; #1;
        model_reset();
        check_regs("rand reset");
        check_out("rand reset out");
        @(negedge clk); rst_n = 1'b1;
      end else begin
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        sel = 1'($urandom);
        en  = 1'($urandom);
        #1; check_out("rand out");
        tick();
        check_regs("rand");
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mux2way5_sel.md
Name: mux2way5_sel

Overview:
- 2-input, WIDTH-bit (default 5) selector used in the MIPS datapath, e.g. register-destination choice (rt vs rd).
- Provides a purely combinational output `out` for same-cycle datapath use.
- Also provides a registered copy `out_q` and a registered select `sel_q` for pipeline-stage use.
- One clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 5, data width of `a`, `b`, `out`, `out_q`.
- CNT_W, 8, width of the select-switch counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- a  input  WIDTH  data input 0, chosen when sel=0.
- b  input  WIDTH  data input 1, chosen when sel=1.
- sel  input  1  select.
- en  input  1  capture enable for the registered outputs.
- out  output  WIDTH  combinational mux result.
- out_q  output  WIDTH  registered mux result.
- sel_q  output  1  registered select.
- switch_cnt  output  CNT_W  count of sel transitions (present only with the optional feature).

Behaviour:
- One clock, `clk`; reset is asynchronous and active-low, `rst_n`.

Combinational path:
- out = (sel == 0) ? a : b.
- Zero latency; reacts to any change on a, b or sel with no clock involvement.
- Unaffected by rst_n and en.
- sel is 1 bit, so there are no undefined encodings.
- Same-width pass-through: no extension or truncation.

Registered path:
- On rst_n falling (asynchronous): out_q = 0, sel_q = 0, switch_cnt = 0.
- These values hold while rst_n = 0.
- At a rising clk edge with rst_n = 1 and en = 1: out_q <= (sel ? b : a); sel_q <= sel.
- With en = 0: out_q and sel_q hold.
- Latency: out_q equals `out` as sampled at the previous enabled edge (1 cycle).

Boundary conditions:
- Reset asserted mid-operation clears the registers immediately, without waiting for a clock edge. `out` keeps tracking its inputs.
- Reset deassertion is assumed synchronous to clk, with no capture on the deassertion edge itself. The first capture occurs at the next rising edge with en = 1.
- a == b: out = a regardless of sel.
- Simultaneous change of sel and data: `out` reflects the new values after settle; `out_q` captures whatever `out` is at the edge.

Optional Feature:
Macro MUX2WAY5_SWITCH_CNT_EN.

Defined:
- `switch_cnt` port exists.
- Register `sel_prev` (reset 0) updates with sel on every rising edge, regardless of en.
- switch_cnt increments by 1 on each edge where sel != sel_prev.
- Saturates at 2^CNT_W − 1; no wrap.
- Reset clears both switch_cnt and sel_prev.

Not defined:
- `switch_cnt` port and all counter logic are absent.
- All other behaviour is identical.

Test Plan:
- Combinational sweep: a = 0..15, b = 0, sel toggles every 5 time units -> out = a when sel = 0, out = 0 when sel = 1 (e.g. a = 7, sel = 0 -> out = 7).
- Second-input sweep: a = 15, b = 0..15 incrementing, sel toggling -> out = b when sel = 1 (b = 9 -> out = 9), out = 15 when sel = 0.
- Registered path: rst_n low -> out_q = 0, sel_q = 0 with no clock. Release; a = 5'd3, b = 5'd28, sel = 1, en = 1, one edge -> out_q = 28, sel_q = 1. Next edge with en = 0, sel = 0 -> out_q stays 28.
- Asynchronous reset mid-operation: out_q = 28, drop rst_n between edges -> out_q = 0 immediately; out still = a or b per sel.
- Full-width values: a = 5'b11111, b = 5'b00000 -> out = 31 / 0 for sel = 0 / 1; no truncation.
- With MUX2WAY5_SWITCH_CNT_EN and CNT_W = 2: toggle sel on 5 consecutive edges -> switch_cnt = 1, 2, 3, 3, 3 (saturates). Reset -> 0.
